// File: rtl/seg_scan_rx.sv
// seg_scan_rx: monitor for the six-digit multiplexed seven-segment scan bus.
// Registers the scan lines and waits for each digit enable to settle. It then
// decodes the segment pattern back to BCD and assembles six-digit frames,
// which are published atomically.
module seg_scan_rx #(
  parameter int unsigned SETTLE_CYC = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  i_seg,
  input  logic        i_seg_dp,
  input  logic [5:0]  i_seg_enb,
  output logic [23:0] o_digits,
  output logic [5:0]  o_dp,
  output logic        o_frame_vld,
  output logic        o_err,
  output logic [1:0]  o_err_code
);

  typedef enum logic {
    ST_IDLE,
    ST_COLLECT
  } state_t;

  localparam logic [7:0] CAP_CNT = 8'(SETTLE_CYC - 1);

  logic [6:0]  r_seg;
  logic        r_seg_dp;
  logic [5:0]  r_enb;
  logic [7:0]  r_cnt;

  state_t      r_state;
  logic [2:0]  r_exp;
  logic [23:0] r_shadow;
  logic [5:0]  r_shadow_dp;
  logic        r_commit;
  logic        r_err_p;
  logic [1:0]  r_err_c;

  logic [5:0]  w_low;
  logic        w_onehot;
  logic        w_cap;
  logic [2:0]  w_idx;
  logic [3:0]  w_dec;
  logic        w_bad;

  // Input register plus settle counter. The counter clears on the same edge
  // that loads a changed enable, so its value equals edges since that load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_seg    <= '0;
      r_seg_dp <= 1'b0;
      r_enb    <= '1;
      r_cnt    <= '0;
    end else begin
      r_seg    <= i_seg;
      r_seg_dp <= i_seg_dp;
      r_enb    <= i_seg_enb;
      if (i_seg_enb != r_enb) begin
        r_cnt <= '0;
      end else if (r_cnt != '1) begin
        r_cnt <= r_cnt + 8'd1;
      end
    end
  end

  // Capture qualification, enable index and segment decode.
  always_comb begin
    w_low    = ~r_enb;
    w_onehot = (w_low != '0) && ((w_low & (w_low - 6'd1)) == '0);
    w_cap    = (r_cnt == CAP_CNT) && (r_enb != '1);
    w_idx    = '0;
    for (int unsigned i = 0; i < 6; i++) begin
      if (w_low[i]) begin
        w_idx = 3'(i);
      end
    end
    w_bad = 1'b0;
    case (r_seg)
      7'h7E:   w_dec = 4'd0;
      7'h30:   w_dec = 4'd1;
      7'h6D:   w_dec = 4'd2;
      7'h79:   w_dec = 4'd3;
      7'h33:   w_dec = 4'd4;
      7'h5B:   w_dec = 4'd5;
      7'h5F:   w_dec = 4'd6;
      7'h70:   w_dec = 4'd7;
      7'h7F:   w_dec = 4'd8;
      7'h73:   w_dec = 4'd9;
      7'h00:   w_dec = 4'hF;
      default: begin
        w_dec = 4'hE;
        w_bad = 1'b1;
      end
    endcase
  end

  // Frame FSM. Captures update the shadow and stage commit/error flags, which
  // reach the outputs on the next edge so a digit-5 error and its commit
  // appear together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_exp       <= '0;
      r_shadow    <= '1;
      r_shadow_dp <= '0;
      r_commit    <= 1'b0;
      r_err_p     <= 1'b0;
      r_err_c     <= '0;
      o_digits    <= '1;
      o_dp        <= '0;
      o_frame_vld <= 1'b0;
      o_err       <= 1'b0;
      o_err_code  <= '0;
    end else begin
      o_frame_vld <= r_commit;
      o_err       <= r_err_p;
      if (r_err_p) begin
        o_err_code <= r_err_c;
      end
      if (r_commit) begin
        o_digits <= r_shadow;
        o_dp     <= r_shadow_dp;
      end
      r_commit <= 1'b0;
      r_err_p  <= 1'b0;

      if (w_cap) begin
        if (!w_onehot) begin
          r_err_p <= 1'b1;
          r_err_c <= 2'd2;
          r_state <= ST_IDLE;
          r_exp   <= '0;
        end else begin
          case (r_state)
            ST_IDLE: begin
              if (w_idx == 3'd0) begin
                r_shadow[3:0]  <= w_dec;
                r_shadow_dp[0] <= r_seg_dp;
                r_exp          <= 3'd1;
                r_state        <= ST_COLLECT;
                if (w_bad) begin
                  r_err_p <= 1'b1;
                  r_err_c <= 2'd1;
                end
              end
            end
            ST_COLLECT: begin
              if (w_idx == r_exp) begin
                r_shadow[{w_idx, 2'b00} +: 4] <= w_dec;
                r_shadow_dp[w_idx]            <= r_seg_dp;
                if (w_bad) begin
                  r_err_p <= 1'b1;
                  r_err_c <= 2'd1;
                end
                if (w_idx == 3'd5) begin
                  r_commit <= 1'b1;
                  r_state  <= ST_IDLE;
                  r_exp    <= '0;
                end else begin
                  r_exp <= r_exp + 3'd1;
                end
              end else begin
                // Order error takes the single error pulse even if the
                // restarting digit-0 pattern is also bad.
                r_err_p <= 1'b1;
                r_err_c <= 2'd3;
                if (w_idx == 3'd0) begin
                  r_shadow[3:0]  <= w_dec;
                  r_shadow_dp[0] <= r_seg_dp;
                  r_exp          <= 3'd1;
                end else begin
                  r_state <= ST_IDLE;
                  r_exp   <= '0;
                end
              end
            end
            default: begin
              r_state <= ST_IDLE;
              r_exp   <= '0;
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_rx.sv
// Bench for seg_scan_rx: scripted and random scan sequences checked against a
// period-level behavioural model of capture and frame assembly.
module tb_seg_scan_rx;

  localparam int S = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [6:0]  i_seg = '0;
  logic        i_seg_dp = 1'b0;
  logic [5:0]  i_seg_enb = '1;
  logic [23:0] o_digits;
  logic [5:0]  o_dp;
  logic        o_frame_vld;
  logic        o_err;
  logic [1:0]  o_err_code;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct packed {
    logic [5:0] enb;
    logic [6:0] seg;
    logic       dp;
    logic [7:0] hold;
    logic       glitch;
  } period_t;

  // Event word: {frame, err, code, digits, dp}
  period_t     per_q[$];
  logic [33:0] exp_q[$];
  logic [33:0] got_q[$];

  logic        m_coll;
  int          m_e;
  logic [3:0]  m_sh[6];
  logic        m_shdp[6];
  logic [23:0] m_dig;
  logic [5:0]  m_dp;
  logic [1:0]  m_code;

  seg_scan_rx #(.SETTLE_CYC(S)) dut (
    .clk(clk), .rst(rst), .i_seg(i_seg), .i_seg_dp(i_seg_dp), .i_seg_enb(i_seg_enb),
    .o_digits(o_digits), .o_dp(o_dp), .o_frame_vld(o_frame_vld), .o_err(o_err),
    .o_err_code(o_err_code)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst && (o_frame_vld || o_err))
      got_q.push_back({o_frame_vld, o_err, o_err_code, o_digits, o_dp});
  end

  function automatic logic [6:0] seg_of(input logic [3:0] v);
    case (v)
      4'd0: return 7'h7E; 4'd1: return 7'h30; 4'd2: return 7'h6D; 4'd3: return 7'h79;
      4'd4: return 7'h33; 4'd5: return 7'h5B; 4'd6: return 7'h5F; 4'd7: return 7'h70;
      4'd8: return 7'h7F; 4'd9: return 7'h73;
      default: return 7'h00;
    endcase
  endfunction

  function automatic logic [5:0] enb_of(input int k);
    logic [5:0] one;
    one = 6'b000001;
    return ~(one << k);
  endfunction

  task automatic model_reset();
    m_coll = 1'b0; m_e = 0; m_dig = 24'hFFFFFF; m_dp = '0; m_code = '0;
    for (int j = 0; j < 6; j++) begin m_sh[j] = 4'hF; m_shdp[j] = 1'b0; end
  endtask

  // Works per enable period: a period captures only if held for S cycles and
  // some digit is selected; frame rules are then applied to the capture list.
  task automatic model_run();
    foreach (per_q[i]) begin
      int nlow, k;
      logic [3:0] d;
      logic bad, fr, er;
      logic [1:0] cd;
      if (int'(per_q[i].hold) < S || per_q[i].enb == 6'h3F) continue;
      nlow = 0; k = 0;
      for (int b = 0; b < 6; b++) if (!per_q[i].enb[b]) begin nlow++; k = b; end
      fr = 1'b0; er = 1'b0; cd = 2'd0;
      if (nlow > 1) begin
        er = 1'b1; cd = 2'd2; m_coll = 1'b0;
      end else begin
        d = 4'hE; bad = 1'b1;
        if (per_q[i].seg == 7'h00) begin d = 4'hF; bad = 1'b0; end
        for (int v = 0; v < 10; v++)
          if (seg_of(4'(v)) == per_q[i].seg) begin d = 4'(v); bad = 1'b0; end
        if (!m_coll) begin
          if (k == 0) begin
            m_sh[0] = d; m_shdp[0] = per_q[i].dp; m_coll = 1'b1; m_e = 1;
            if (bad) begin er = 1'b1; cd = 2'd1; end
          end
        end else if (k == m_e) begin
          m_sh[k] = d; m_shdp[k] = per_q[i].dp; m_e++;
          if (bad) begin er = 1'b1; cd = 2'd1; end
          if (k == 5) begin
            fr = 1'b1; m_coll = 1'b0;
            for (int j = 0; j < 6; j++) begin m_dig[4*j +: 4] = m_sh[j]; m_dp[j] = m_shdp[j]; end
          end
        end else begin
          er = 1'b1; cd = 2'd3;
          if (k == 0) begin m_sh[0] = d; m_shdp[0] = per_q[i].dp; m_e = 1; end
          else m_coll = 1'b0;
        end
      end
      if (er) m_code = cd;
      if (fr || er) exp_q.push_back({fr, er, m_code, m_dig, m_dp});
    end
  endtask

  task automatic add(input logic [5:0] enb, input logic [6:0] seg, input logic dp,
                     input int hold, input logic gl);
    period_t p;
    if (per_q.size() > 0 && per_q[$].enb == enb) begin
      p.enb = 6'h3F; p.seg = 7'h00; p.dp = 1'b0; p.hold = 8'd1; p.glitch = 1'b0;
      per_q.push_back(p);
    end
    p.enb = enb; p.seg = seg; p.dp = dp; p.hold = 8'(hold); p.glitch = gl;
    per_q.push_back(p);
  endtask

  task automatic add_frame(input logic [23:0] digs, input logic [5:0] dps, input int hold);
    for (int k = 0; k < 6; k++) add(enb_of(k), seg_of(digs[4*k +: 4]), dps[k], hold, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1; i_seg_enb = '1; i_seg = '0; i_seg_dp = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    got_q.delete(); per_q.delete(); exp_q.delete();
    model_reset();
  endtask

  task automatic run_periods();
    foreach (per_q[i]) begin
      i_seg_enb = per_q[i].enb; i_seg_dp = per_q[i].dp;
      if (per_q[i].glitch && per_q[i].hold >= 2) begin
        i_seg = 7'($urandom);
        @(posedge clk); #1;
        i_seg = per_q[i].seg;
        repeat (int'(per_q[i].hold) - 1) @(posedge clk);
      end else begin
        i_seg = per_q[i].seg;
        repeat (int'(per_q[i].hold)) @(posedge clk);
      end
      #1;
    end
    i_seg_enb = '1; i_seg = '0; i_seg_dp = 1'b0;
    repeat (S + 4) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk); #1;
    n_chk++; if (o_digits !== 24'hFFFFFF) begin n_fail++; $display("FAIL reset_digits: got %h expected ffffff", o_digits); end
    n_chk++; if (o_dp !== 6'h00) begin n_fail++; $display("FAIL reset_dp: got %h expected 00", o_dp); end
    n_chk++; if (o_frame_vld !== 1'b0) begin n_fail++; $display("FAIL reset_vld: got %b expected 0", o_frame_vld); end
    n_chk++; if (o_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", o_err); end
    n_chk++; if (o_err_code !== 2'd0) begin n_fail++; $display("FAIL reset_code: got %0d expected 0", o_err_code); end
  endtask

  task automatic test_clean_frame();
    do_reset();
    add_frame(24'hFF4321, 6'h00, 10);
    model_run(); run_periods();
    n_chk++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL clean_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      n_chk++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL clean_ev[%0d]: got %h expected %h", i, got_q[i], exp_q[i]); end
    end
    n_chk++; if (o_digits !== 24'hFF4321) begin n_fail++; $display("FAIL clean_digits: got %h expected ff4321", o_digits); end
    n_chk++; if (got_q.size() != 1) begin n_fail++; $display("FAIL clean_pulses: got %0d expected 1", got_q.size()); end
  endtask

  task automatic test_short_enable();
    do_reset();
    add_frame(24'hFF4321, 6'h00, 10);
    per_q[1].hold = 8'd3;
    model_run(); run_periods();
    n_chk++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL short_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      n_chk++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL short_ev[%0d]: got %h expected %h", i, got_q[i], exp_q[i]); end
    end
    n_chk++; if (got_q.size() < 1 || got_q[0][33:30] !== 4'b0111) begin n_fail++; $display("FAIL short_err3: got %0d events expected one code-3 error", got_q.size()); end
    n_chk++; if (o_digits !== 24'hFFFFFF) begin n_fail++; $display("FAIL short_digits: got %h expected ffffff", o_digits); end
  endtask

  task automatic test_bad_pattern();
    do_reset();
    add_frame(24'hFF4321, 6'h00, 10);
    per_q[1].seg = 7'h01;
    add_frame(24'hFF4321, 6'h21, 10);
    per_q[11].seg = 7'h01;
    model_run(); run_periods();
    n_chk++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL bad_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      n_chk++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL bad_ev[%0d]: got %h expected %h", i, got_q[i], exp_q[i]); end
    end
    n_chk++; if (got_q.size() < 2 || got_q[1][29:6] !== 24'hFF43E1) begin n_fail++; $display("FAIL bad_first_frame: got %0d events, expected ff43e1 commit second", got_q.size()); end
    n_chk++; if (o_digits !== 24'hEF4321 || o_dp !== 6'h21) begin n_fail++; $display("FAIL bad_d5_frame: got %h/%h expected ef4321/21", o_digits, o_dp); end
    n_chk++; if (got_q.size() < 1 || got_q[$][33:30] !== 4'b1101) begin n_fail++; $display("FAIL bad_d5_coincide: got %0d events, expected final frame+err code 1", got_q.size()); end
  endtask

  task automatic test_not_onehot();
    do_reset();
    add(6'b111100, seg_of(4'd8), 1'b0, 10, 1'b0);
    add_frame(24'h098765, 6'h00, 10);
    model_run(); run_periods();
    n_chk++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL onehot_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      n_chk++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL onehot_ev[%0d]: got %h expected %h", i, got_q[i], exp_q[i]); end
    end
    n_chk++; if (o_digits !== 24'h098765 || o_err_code !== 2'd2) begin n_fail++; $display("FAIL onehot_final: got %h code %0d expected 098765 code 2", o_digits, o_err_code); end
  endtask

  task automatic test_midscan();
    do_reset();
    for (int k = 3; k < 6; k++) add(enb_of(k), seg_of(4'(k)), 1'b0, 8, 1'b0);
    add_frame(24'h012345, 6'h3F, 8);
    model_run(); run_periods();
    n_chk++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL midscan_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      n_chk++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL midscan_ev[%0d]: got %h expected %h", i, got_q[i], exp_q[i]); end
    end
    n_chk++; if (o_digits !== 24'h012345 || o_dp !== 6'h3F || o_err_code !== 2'd0) begin n_fail++; $display("FAIL midscan_final: got %h/%h code %0d expected 012345/3f code 0", o_digits, o_dp, o_err_code); end
  endtask

  task automatic test_reset_midframe();
    do_reset();
    add_frame(24'h456789, 6'h15, 8);
    run_periods();
    per_q.delete();
    for (int k = 0; k < 3; k++) add(enb_of(k), seg_of(4'(k + 1)), 1'b1, 8, 1'b0);
    run_periods();
    n_chk++; if (o_digits !== 24'h456789) begin n_fail++; $display("FAIL rstmid_pre: got %h expected 456789", o_digits); end
    rst = 1'b1;
    #1;
    n_chk++; if (o_digits !== 24'hFFFFFF || o_dp !== 6'h00) begin n_fail++; $display("FAIL rstmid_async: got %h/%h expected ffffff/00", o_digits, o_dp); end
    @(posedge clk); #1;
    rst = 1'b0;
    got_q.delete(); per_q.delete(); exp_q.delete(); model_reset();
    @(posedge clk); #1;
    add_frame(24'hF01234, 6'h02, 9);
    model_run(); run_periods();
    n_chk++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL rstmid_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      n_chk++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rstmid_ev[%0d]: got %h expected %h", i, got_q[i], exp_q[i]); end
    end
    n_chk++; if (o_digits !== 24'hF01234) begin n_fail++; $display("FAIL rstmid_final: got %h expected f01234", o_digits); end
  endtask

  task automatic test_latency();
    do_reset();
    for (int k = 0; k < 5; k++) add(enb_of(k), seg_of(4'(k + 1)), 1'b0, S, 1'b0);
    run_periods();
    i_seg_enb = 6'b011111; i_seg = seg_of(4'd7); i_seg_dp = 1'b1;
    repeat (S) @(posedge clk); #1;
    n_chk++; if (o_frame_vld !== 1'b0) begin n_fail++; $display("FAIL lat_early: got vld %b expected 0", o_frame_vld); end
    @(posedge clk); #1;
    n_chk++; if (o_frame_vld !== 1'b0 || o_digits !== 24'hFFFFFF) begin n_fail++; $display("FAIL lat_capture_edge: got vld %b digits %h expected 0 ffffff", o_frame_vld, o_digits); end
    @(posedge clk); #1;
    n_chk++; if (o_frame_vld !== 1'b1 || o_digits !== 24'h754321 || o_dp !== 6'h20) begin n_fail++; $display("FAIL lat_commit: got vld %b digits %h dp %h expected 1 754321 20", o_frame_vld, o_digits, o_dp); end
    @(posedge clk); #1;
    n_chk++; if (o_frame_vld !== 1'b0) begin n_fail++; $display("FAIL lat_pulse_width: got vld %b expected 0", o_frame_vld); end
    i_seg_enb = '1; i_seg = '0; i_seg_dp = 1'b0;
    repeat (S + 2) @(posedge clk); #1;
  endtask

  task automatic test_random();
    for (int r = 0; r < 4; r++) begin
      int nxt;
      nxt = 0;
      do_reset();
      for (int n = 0; n < 30; n++) begin
        int c, k, a, b, h;
        logic [5:0] enb;
        logic [6:0] sg;
        c = int'($urandom_range(0, 99));
        if (c < 6) begin
          a = int'($urandom_range(0, 5)); b = (a + int'($urandom_range(1, 5))) % 6;
          enb = enb_of(a) & enb_of(b);
        end else begin
          k = (c < 14) ? int'($urandom_range(0, 5)) : nxt;
          nxt = (k + 1) % 6;
          enb = enb_of(k);
        end
        h = ($urandom_range(0, 99) < 15) ? int'($urandom_range(1, S - 1)) : int'($urandom_range(S, S + 6));
        c = int'($urandom_range(0, 99));
        sg = (c < 70) ? seg_of(4'($urandom_range(0, 9))) : (c < 85) ? 7'h00 : 7'($urandom);
        add(enb, sg, 1'($urandom), h, 1'($urandom));
      end
      model_run(); run_periods();
      n_chk++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL rand%0d_count: got %0d expected %0d", r, got_q.size(), exp_q.size()); end
      foreach (exp_q[i]) if (i < got_q.size()) begin
        n_chk++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rand%0d_ev[%0d]: got %h expected %h", r, i, got_q[i], exp_q[i]); end
      end
      n_chk++; if (o_err_code !== m_code || o_digits !== m_dig || o_dp !== m_dp) begin n_fail++; $display("FAIL rand%0d_hold: got %0d/%h/%h expected %0d/%h/%h", r, o_err_code, o_digits, o_dp, m_code, m_dig, m_dp); end
    end
  endtask

  initial begin
    test_reset();
    test_clean_frame();
    test_short_enable();
    test_bad_pattern();
    test_not_onehot();
    test_midscan();
    test_reset_midframe();
    test_latency();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
